// File: rtl/instr_queue.sv
// instr_queue: show-ahead circular FIFO buffering fetched instructions (instr, pc, predicted pc) for issue.
module instr_queue #(
  parameter int DEPTH_LOG = 4,
  parameter int SLACK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_pred_pc,
  output logic        is_full,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_pc,
  input  logic        pop
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] HIGH = (DEPTH_LOG + 1)'(DEPTH - SLACK);
  logic [95:0] mem [DEPTH];
  logic [DEPTH_LOG-1:0] head, tail;
  logic [DEPTH_LOG:0] count;
  logic push_ok, pop_ok;
  assign push_ok = push && count != FULL;
  assign pop_ok = pop && count != '0;
  assign is_full = count >= HIGH;
  assign out_valid = count != '0;
  assign {out_instr, out_pc, out_pred_pc} = out_valid ? mem[head] : 96'd0;
  always_ff @(posedge clk)
    if (rdy && !flush && push_ok) mem[tail] <= {push_instr, push_pc, push_pred_pc};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        tail <= tail + DEPTH_LOG'(push_ok);
        head <= head + DEPTH_LOG'(pop_ok);
        count <= count + (DEPTH_LOG + 1)'(push_ok) - (DEPTH_LOG + 1)'(pop_ok);
      end
    end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: vector table plus scoreboard queue model of the instruction FIFO.
module tb_instr_queue;
  logic clk = 0, rst = 1, rdy = 0, flush = 0, push = 0, pop = 0;
  logic [31:0] push_instr = 0, push_pc = 0, push_pred_pc = 0;
  logic is_full, out_valid;
  logic [31:0] out_instr, out_pc, out_pred_pc;
  int n_cmp = 0, n_bad = 0;
  logic [95:0] sb[$];
  instr_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .push(push),
    .push_instr(push_instr), .push_pc(push_pc), .push_pred_pc(push_pred_pc),
    .is_full(is_full), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pred_pc(out_pred_pc), .pop(pop)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic p, pp, f, r;
    logic [31:0] pc;
    logic ev, ef;
    logic [31:0] epc;
  } vec_t;
  vec_t vt[9];
  task automatic cmp(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check(input string nm);
    cmp({nm, ".valid"}, 96'(out_valid), 96'(sb.size() != 0));
    cmp({nm, ".full"}, 96'(is_full), 96'(sb.size() >= 15));
    cmp({nm, ".data"}, {out_instr, out_pc, out_pred_pc}, sb.size() != 0 ? sb[0] : 96'd0);
  endtask
  task automatic step(input logic p, input logic pp, input logic f, input logic r,
                      input logic [31:0] pc, input string nm);
    logic [31:0] ins;
    logic push_ok, pop_ok;
    ins = pc == 0 ? 32'h13 : 32'h13 + pc;
    push = p; pop = pp; flush = f; rdy = r;
    push_instr = ins; push_pc = pc; push_pred_pc = pc + 4;
    if (r) begin
      if (f) sb.delete();
      else begin
        push_ok = p && sb.size() < 16;
        pop_ok = pp && sb.size() != 0;
        if (pop_ok) void'(sb.pop_front());
        if (push_ok) sb.push_back({ins, pc, pc + 32'd4});
      end
    end
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0; rdy = 1;
    check(nm);
  endtask
  initial begin
    vt[0] = '{1, 0, 0, 1, 32'h0,  1, 0, 32'h0};
    vt[1] = '{0, 1, 0, 1, 32'h0,  0, 0, 32'h0};
    vt[2] = '{1, 0, 0, 1, 32'h8,  1, 0, 32'h8};
    vt[3] = '{1, 0, 0, 1, 32'hC,  1, 0, 32'h8};
    vt[4] = '{1, 1, 0, 1, 32'h10, 1, 0, 32'hC};
    vt[5] = '{0, 1, 0, 1, 32'h0,  1, 0, 32'h10};
    vt[6] = '{0, 1, 0, 1, 32'h0,  0, 0, 32'h0};
    vt[7] = '{0, 1, 0, 1, 32'h0,  0, 0, 32'h0};
    vt[8] = '{1, 0, 0, 0, 32'h20, 0, 0, 32'h0};
    #12;
    check("reset");
    rst = 0; rdy = 1;
    #10;
    for (int i = 0; i < 9; i++) begin
      step(vt[i].p, vt[i].pp, vt[i].f, vt[i].r, vt[i].pc, $sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.tvalid", i), 96'(out_valid), 96'(vt[i].ev));
      cmp($sformatf("vec%0d.tfull", i), 96'(is_full), 96'(vt[i].ef));
      cmp($sformatf("vec%0d.tpc", i), 96'(out_pc), 96'(vt[i].epc));
      if (i == 0) cmp("single.instr", {out_instr, out_pred_pc}, {32'h13, 32'h4});
    end
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 0, 1, 32'(4 * i), $sformatf("fill%0d", i));
      if (i == 13) cmp("fill.notfull14", 96'(is_full), 96'd0);
      if (i == 14) cmp("fill.full15", 96'(is_full), 96'd1);
    end
    cmp("fill.head", 96'(out_pc), 96'h0);
    for (int i = 0; i < 16; i++) begin
      cmp($sformatf("drain%0d.pc", i), 96'(out_pc), 96'(4 * i));
      step(0, 1, 0, 1, 0, $sformatf("drain%0d", i));
    end
    cmp("drain.empty", 96'(out_valid), 96'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'(32'h200 + 4 * i), "prefill");
    for (int i = 0; i < 40; i++) begin
      cmp($sformatf("wrap%0d.pc", i), 96'(out_pc), 96'(32'h200 + 4 * i));
      step(1, 1, 0, 1, 32'(32'h20C + 4 * i), $sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, "wrapdrain");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 32'(32'h40 + 4 * i), "fl_pre");
    step(1, 1, 1, 1, 32'h80, "flush");
    cmp("flush.valid", 96'(out_valid), 96'd0);
    step(1, 0, 0, 1, 32'h100, "postflush");
    cmp("postflush.pc", 96'(out_pc), 96'h100);
    step(0, 1, 0, 1, 0, "postflush_pop");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 32'(32'h300 + 4 * i), "rdy_pre");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 32'h400, $sformatf("rdylow%0d", i));
      cmp($sformatf("rdylow%0d.pc", i), 96'(out_pc), 96'h300);
    end
    for (int i = 0; i < 4; i++) begin
      cmp($sformatf("resume%0d.pc", i), 96'(out_pc), 96'(32'h300 + 4 * i));
      step(0, 1, 0, 1, 0, $sformatf("resume%0d", i));
    end
    cmp("resume.empty", 96'(out_valid), 96'd0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < (r == 0 ? 7 : 15); i++) step(1, 0, 0, 1, 32'(32'h500 + 4 * i), "ar_pre");
      #2;
      rst = 1;
      sb.delete();
      #1;
      check($sformatf("async_rst%0d", r));
      rst = 0;
      @(posedge clk);
      #1;
      check($sformatf("after_rst%0d", r));
    end
    step(1, 0, 0, 1, 32'h600, "post_rst_push");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
